// File: rtl/corelet_ctrl.sv
// Instruction sequencer for one corelet tile pass: weight load, activation
// fill, execute, output drain and optional accumulate. Drives a fully
// registered 34-bit instruction word plus busy/done handshakes.
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               acc_en,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic [len_bw-1:0]  len,
    input  logic               l0_full,
    input  logic               ofifo_valid,
    output logic [33:0]        inst,
    output logic               busy,
    output logic               done
);

    // Degenerate array shapes make the phase counters meaningless.
    if (row < 1 || col < 1) begin : g_param_check
        $error("corelet_ctrl: row and col must be at least 1");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_WLD_X, S_WLD_A, S_WLD_WAIT, S_ACT_X, S_EXEC, S_OUT, S_ACC, S_DONE
    } state_t;

    // Field order matches the corelet instruction bit map, MSB first.
    typedef struct packed {
        logic               acc;
        logic               cen_pmem;
        logic               wen_pmem;
        logic [addr_bw-1:0] a_pmem;
        logic               cen_xmem;
        logic               wen_xmem;
        logic [addr_bw-1:0] a_xmem;
        logic               ofifo_rd;
        logic               ififo_wr;
        logic               ififo_rd;
        logic               l0_rd;
        logic               l0_wr;
        logic               execute;
        logic               load;
    } inst_t;

    // One extra bit so counters can reach len or col without wrapping.
    typedef logic [len_bw:0] cnt_t;

    // Active-low SRAM controls parked high, everything else zero.
    function automatic inst_t idle_word();
        inst_t w;
        w          = '0;
        w.cen_pmem = 1'b1;
        w.wen_pmem = 1'b1;
        w.cen_xmem = 1'b1;
        w.wen_xmem = 1'b1;
        return w;
    endfunction

    state_t             state_q, state_d;
    inst_t              inst_q, inst_d;
    cnt_t               k_q, k_d;      // xmem reads issued in the current fill phase
    cnt_t               cnt_q, cnt_d;  // cycle counter for fixed-length phases
    cnt_t               j_q, j_d;      // pmem accesses issued
    cnt_t               rd_q, rd_d;    // ofifo reads issued
    logic               done_d;
    logic               capture;
    logic               acc_en_q;
    logic [addr_bw-1:0] w_base_q, x_base_q, p_base_q;
    logic [len_bw-1:0]  len_q;

    cnt_t col_n;
    cnt_t len_n;
    logic xmem_rd_now;

    assign col_n       = cnt_t'(col);
    assign len_n       = cnt_t'(len_q);
    // A read visible on the bus this cycle lands in l0 on the next one.
    assign xmem_rd_now = !inst_q.cen_xmem && inst_q.wen_xmem;

    // Next-state and next-instruction decode.
    // NOTE: every signal gets a default at the top so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        j_d           = j_q;
        rd_d          = rd_q;
        done_d        = 1'b0;
        capture       = 1'b0;
        inst_d        = idle_word();
        inst_d.l0_wr  = xmem_rd_now;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    k_d     = '0;
                    cnt_d   = '0;
                    j_d     = '0;
                    rd_d    = '0;
                    state_d = (len != '0) ? S_WLD_X : S_DONE;
                end
            end
            S_WLD_X: begin
                if (k_q == col_n) begin
                    // Trailing cycle: only the last l0_wr goes out.
                    state_d = S_WLD_A;
                    cnt_d   = '0;
                end else begin
                    // Address is held at the next read even while stalled.
                    inst_d.a_xmem = w_base_q + addr_bw'(k_q);
                    if (!l0_full) begin
                        inst_d.cen_xmem = 1'b0;
                        k_d             = k_q + 1'b1;
                    end
                end
            end
            S_WLD_A: begin
                inst_d.l0_rd = 1'b1;
                inst_d.load  = 1'b1;
                if (cnt_q == col_n - 1'b1) begin
                    state_d = S_WLD_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WLD_WAIT: begin
                if (cnt_q == col_n - 1'b1) begin
                    state_d = S_ACT_X;
                    k_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACT_X: begin
                if (k_q == len_n) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    inst_d.a_xmem = x_base_q + addr_bw'(k_q);
                    if (!l0_full) begin
                        inst_d.cen_xmem = 1'b0;
                        k_d             = k_q + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                inst_d.l0_rd   = 1'b1;
                inst_d.execute = 1'b1;
                if (cnt_q == len_n - 1'b1) begin
                    state_d = S_OUT;
                    j_d     = '0;
                    rd_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (ofifo_valid && rd_q != len_n) begin
                    inst_d.ofifo_rd = 1'b1;
                    rd_d            = rd_q + 1'b1;
                end
                // The row popped last cycle is written to pmem now.
                if (inst_q.ofifo_rd) begin
                    inst_d.cen_pmem = 1'b0;
                    inst_d.wen_pmem = 1'b0;
                    inst_d.a_pmem   = p_base_q + addr_bw'(j_q);
                    j_d             = j_q + 1'b1;
                    if (j_q == len_n - 1'b1) begin
                        state_d = acc_en_q ? S_ACC : S_DONE;
                        j_d     = '0;
                    end
                end
            end
            S_ACC: begin
                inst_d.acc      = 1'b1;
                inst_d.cen_pmem = 1'b0;
                inst_d.a_pmem   = p_base_q + addr_bw'(j_q);
                if (j_q == len_n - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and the registered instruction word.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            inst_q  <= idle_word();
            done    <= 1'b0;
            k_q     <= '0;
            cnt_q   <= '0;
            j_q     <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            done    <= done_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            rd_q    <= rd_d;
        end
    end

    // Pass configuration, frozen when start is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_en_q <= 1'b0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            len_q    <= '0;
        end else if (capture) begin
            acc_en_q <= acc_en;
            w_base_q <= w_base;
            x_base_q <= x_base;
            p_base_q <= p_base;
            len_q    <= len;
        end
    end

    assign inst = inst_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: a bus monitor compares every SRAM
// access against scoreboard queues filled when each pass is launched.
module tb_corelet_ctrl;

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, acc_en, l0_full, ofifo_valid;
    logic [10:0] w_base, x_base, p_base;
    logic [10:0] len;
    logic [33:0] inst;
    logic        busy, done;

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .acc_en(acc_en),
        .w_base(w_base), .x_base(x_base), .p_base(p_base), .len(len),
        .l0_full(l0_full), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and per-pass tallies.
    logic [10:0] xq[$];
    logic [10:0] pq[$];
    logic [10:0] aq[$];
    int  load_cnt, exec_cnt, l0wr_cnt, ofrd_cnt, acc_cnt;
    int  exp_load, exp_exec, exp_l0wr, exp_ofrd, exp_acc;
    bit  exp_done, done_seen, bad;
    logic prev_rd, prev_ofrd;
    logic full_s, valid_s;

    task automatic clear_tallies();
        xq.delete(); pq.delete(); aq.delete();
        load_cnt = 0; exec_cnt = 0; l0wr_cnt = 0; ofrd_cnt = 0; acc_cnt = 0;
        bad = 1'b0; prev_rd = 1'b0; prev_ofrd = 1'b0;
        exp_done = 1'b0; done_seen = 1'b0;
    endtask

    // Bus monitor: inputs sampled at the edge, outputs 1 ns later.
    always begin
        logic x_rd;
        @(posedge clk);
        full_s  = l0_full;
        valid_s = ofifo_valid;
        #1;
        x_rd = !inst[19] && inst[18];
        if (full_s) begin
            check("stall_cen", inst[19], 1'b1);
            if (xq.size() > 0) check("stall_addr", inst[17:7], xq[0]);
        end
        if (x_rd) begin
            if (xq.size() == 0) check("x_extra", 1, 0);
            else check("x_addr", inst[17:7], xq.pop_front());
        end
        if (inst[2] || prev_rd) check("l0_wr", inst[2], prev_rd);
        if (inst[2]) l0wr_cnt++;
        if (inst[0]) load_cnt++;
        if (inst[1]) exec_cnt++;
        if ((inst[0] || inst[1]) && !inst[3]) bad = 1'b1;
        if (inst[0] && inst[1]) bad = 1'b1;
        if (inst[5:4] != 2'b00) bad = 1'b1;
        if (!inst[19] && !inst[32]) bad = 1'b1;
        if (inst[6]) begin
            ofrd_cnt++;
            if (!valid_s) bad = 1'b1;
        end
        if (!inst[32] && !inst[31]) begin
            check("wr_after_rd", prev_ofrd, 1'b1);
            if (pq.size() == 0) check("p_extra", 1, 0);
            else check("p_addr", inst[30:20], pq.pop_front());
        end
        if (!inst[32] && inst[31]) begin
            acc_cnt++;
            if (!inst[33]) bad = 1'b1;
            if (aq.size() == 0) check("acc_extra", 1, 0);
            else check("acc_addr", inst[30:20], aq.pop_front());
        end
        if (inst[33] && inst[32]) bad = 1'b1;
        prev_rd   = x_rd;
        prev_ofrd = inst[6];
        if (done) begin
            check("done_expected", exp_done, 1'b1);
            check("done_busy", busy, 1'b0);
            check("done_inst", inst, IDLE_WORD);
            check("xq_left", xq.size(), 0);
            check("pq_left", pq.size(), 0);
            check("aq_left", aq.size(), 0);
            check("load_cnt", load_cnt, exp_load);
            check("exec_cnt", exec_cnt, exp_exec);
            check("l0wr_cnt", l0wr_cnt, exp_l0wr);
            check("ofrd_cnt", ofrd_cnt, exp_ofrd);
            check("acc_cnt", acc_cnt, exp_acc);
            check("protocol", bad, 1'b0);
            load_cnt = 0; exec_cnt = 0; l0wr_cnt = 0; ofrd_cnt = 0; acc_cnt = 0;
            bad = 1'b0; exp_done = 1'b0; done_seen = 1'b1;
        end
    end

    // Load the scoreboard for one pass with the given configuration.
    task automatic expect_pass(input logic [10:0] w, input logic [10:0] x, input logic [10:0] p,
                               input int l, input bit a);
        if (l != 0) begin
            for (int k = 0; k < 8; k++) xq.push_back(w + 11'(k));
        end
        for (int k = 0; k < l; k++) begin
            xq.push_back(x + 11'(k));
            pq.push_back(p + 11'(k));
            if (a) aq.push_back(p + 11'(k));
        end
        exp_load = (l != 0) ? 8 : 0;
        exp_exec = l;
        exp_l0wr = (l != 0) ? 8 + l : 0;
        exp_ofrd = l;
        exp_acc  = a ? l : 0;
        exp_done = 1'b1;
        done_seen = 1'b0;
    endtask

    // mode: 0 plain, 1 stall after 3 reads, 2 ofifo pattern 1,0,0,1,
    // 3 reset during EXEC. Also pokes start while busy.
    task automatic run_pass(input logic [10:0] w, input logic [10:0] x, input logic [10:0] p,
                            input int l, input bit a, input int mode);
        logic [3:0] pat;
        int reads;
        int stall_left;
        pat = 4'b1001;
        stall_left = 3;
        expect_pass(w, x, p, l, a);
        @(negedge clk);
        w_base = w; x_base = x; p_base = p; len = 11'(l); acc_en = a;
        ofifo_valid = (mode == 2) ? pat[3] : 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Changes after acceptance must not affect the running pass.
        w_base = 11'($urandom); x_base = 11'($urandom); p_base = 11'($urandom);
        len = 11'($urandom_range(1, 50)); acc_en = ~a;
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            reads = 8 + l + 8 - exp_l0wr + xq.size();
            reads = (8 + l) - xq.size();
            if (mode == 1 && reads >= 3 && stall_left > 0) begin
                l0_full = 1'b1;
                stall_left--;
            end else begin
                l0_full = 1'b0;
            end
            if (mode == 2) ofifo_valid = pat[3 - (c % 4)];
            start = (c == 12);
            if (mode == 3 && exec_cnt > 0) begin
                reset = 1'b0;
                #1;
                check("abort_inst", inst, IDLE_WORD);
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                clear_tallies();
                @(negedge clk);
                reset = 1'b1;
                start = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        l0_full = 1'b0;
        ofifo_valid = 1'b1;
        check("pass_done_seen", done_seen, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; acc_en = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b1;
        w_base = '0; x_base = '0; p_base = '0; len = '0;
        clear_tallies();

        // Reset held with start toggling: outputs stay idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = ~start;
            @(posedge clk);
            #1;
            check("rst_inst", inst, IDLE_WORD);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Basic pass.
        run_pass(11'd0, 11'd8, 11'd0, 4, 1'b0, 0);
        // l0_full stall during weight fetch.
        run_pass(11'd16, 11'd100, 11'd40, 3, 1'b0, 1);
        // ofifo backpressure with accumulate.
        run_pass(11'd0, 11'd8, 11'd0, 2, 1'b1, 2);
        // Address wrap on pmem and xmem.
        run_pass(11'd2044, 11'd2045, 11'd2046, 4, 1'b1, 0);

        // len = 0: straight to DONE, done one cycle later, no SRAM access.
        expect_pass(11'd0, 11'd0, 11'd0, 0, 1'b0);
        @(negedge clk);
        len = '0; acc_en = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        check("len0_busy", busy, 1'b1);
        check("len0_early", done, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("len0_done", done, 1'b1);
        check("len0_idle", busy, 1'b0);
        repeat (2) @(negedge clk);

        // Reset during EXEC, then a clean pass.
        run_pass(11'd0, 11'd8, 11'd0, 6, 1'b0, 3);
        repeat (2) @(negedge clk);
        run_pass(11'd3, 11'd30, 11'd9, 5, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
Instruction sequencer that drives the 34-bit instruction word consumed by the corelet and its xmem/pmem SRAMs. On a start pulse it runs one full tile pass through the weight load, activation fill, execute, output drain and optional accumulate phases. It generates SRAM addresses, chip-enables, write-enables and the l0/ofifo/mac strobes. It sits between the testbench or host and the corelet/SRAM pair.

Parameters:
row, 8, PE rows / l0 lanes
col, 8, PE columns; weight rows loaded per pass
addr_bw, 11, SRAM address width (xmem and pmem)
len_bw, 11, width of activation-vector count

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  single-cycle pass request; sampled only in IDLE
acc_en  input  1  run the ACC phase after OUT
w_base  input  addr_bw  xmem base address of col weight words
x_base  input  addr_bw  xmem base address of activation words
p_base  input  addr_bw  pmem base address for outputs
len  input  len_bw  number of activation vectors (0 allowed)
l0_full  input  1  corelet l0 full; stalls xmem reads
ofifo_valid  input  1  corelet ofifo has a readable row
inst  output  34  instruction word; bit map below
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on pass completion

Behaviour:
- inst map: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load. CEN and WEN are active-low. inst is fully registered.
- Idle word: 34'h1_800C_0000, meaning CEN and WEN high, all addresses and strobes 0. inst takes this value on reset, in IDLE and in DONE. busy=0 and done=0 on reset.
- ififo_wr and ififo_rd (bits 5:4) are always 0.
- Address arithmetic: base + k, truncated modulo 2^addr_bw, so addresses wrap silently.
- SRAM read latency is 1 cycle. Every xmem read issued in cycle t produces l0_wr=1 in cycle t+1.
- States: IDLE, WLD_X, WLD_A, WLD_WAIT, ACT_X, EXEC, OUT, ACC, DONE.
- IDLE: start=1 and len!=0 -> WLD_X, with counters cleared. start=1 and len==0 -> DONE.
- WLD_X: issue a read (CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+k) in each cycle where l0_full=0. k advances only when a read is issued. When l0_full=1, CEN_xmem=1 and k holds. After col reads, spend one extra cycle for the trailing l0_wr, then go to WLD_A.
- WLD_A: l0_rd=1, load=1 for exactly col cycles -> WLD_WAIT.
- WLD_WAIT: idle word for col cycles, so weights settle in the array -> ACT_X.
- ACT_X: same read/stall rules as WLD_X, with A_xmem=x_base+k, for len reads plus one trailing cycle -> EXEC.
- EXEC: l0_rd=1, execute=1 for len cycles -> OUT.
- OUT: in each cycle with ofifo_valid=1, assert ofifo_rd=1. In the following cycle, write pmem (CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+j), then j++. After len writes: acc_en=1 -> ACC, otherwise -> DONE. OUT waits indefinitely with no timeout.
- ACC: acc=1, CEN_pmem=0, WEN_pmem=1, A_pmem=p_base+j for len cycles, with j restarted at 0 -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy drops in the same cycle the state returns to IDLE.
- start is ignored while busy=1. acc_en, the base addresses and len are captured when start is accepted; later changes to these inputs do not affect the running pass.
- Reset assertion mid-pass returns immediately (asynchronously) to IDLE with the idle word and no done pulse.
- The xmem and pmem strobes never overlap within a state. load and execute are never high together.

Test Plan:
- Reset then idle: reset=0 for 3 cycles with start toggling -> inst=34'h1_800C_0000, busy=0, done=0 throughout.
- Basic pass, w_base=0, x_base=8, p_base=0, len=4, acc_en=0, l0_full=0, ofifo_valid=1: expected sequence below.
  - Reads at A_xmem 0..7, each followed one cycle later by l0_wr.
  - 8 cycles of load+l0_rd, then 8 idle cycles.
  - Reads at 8..11, then 4 cycles of execute.
  - 4 pmem writes at 0..3.
  - done pulses once.
- Stall: raise l0_full for cycles 3-5 of WLD_X -> CEN_xmem=1 and A_xmem frozen during the stall; exactly 8 reads complete, addresses 0..7 with no gaps or repeats.
- ofifo backpressure and acc: ofifo_valid toggles 1,0,0,1 with len=2, acc_en=1 -> ofifo_rd and pmem writes occur only after valid cycles; then 2 ACC cycles with acc=1, WEN_pmem=1 at A_pmem 0 and 1.
- Edge cases:
  - len=0 with start -> done one cycle after DONE entry and no SRAM access.
  - p_base=2046, len=4 -> A_pmem = 2046, 2047, 0, 1.
- Mid-pass reset: assert reset=0 during EXEC -> idle word and busy=0 immediately; a new start after release runs a full clean pass.
